// File: rtl/enc_codeword_gen.sv
// ---------------------------------------------------------------------------
// enc_codeword_gen
//   Two-stage pipelined Hamming SECDED encoder. Builds 8/16/32-bit codewords
//   from 4/11/26 data bits. Position p of the codeword is bit p of
//   codeword_out. Parity sits at positions 1,2,4,8,16 (those below N), data
//   fills the remaining positions >= 3 in ascending order, and position 0
//   holds the overall parity of positions 1..N-1.
//
//   Optional feature macro: ENC_ERR_INJECT_EN
//     When defined, adds err_inj / err_inj_pos. These are sampled with
//     data_in on accept. When err_inj is set, codeword bit err_inj_pos is
//     inverted in S2; positions >= N are left alone.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active low
//   in_valid       in   data_in / codeword_width valid
//   in_ready       out  encoder accepts this cycle
//   data_in        in   LSB-aligned data word
//   codeword_width in   00 = 8-bit, 01 = 16-bit, 1x = 32-bit codeword
//   err_inj        in   (ENC_ERR_INJECT_EN) invert one codeword bit
//   err_inj_pos    in   (ENC_ERR_INJECT_EN) bit position to invert
//   out_valid      out  codeword_out valid
//   out_ready      in   downstream accepts codeword
//   codeword_out   out  LSB-aligned codeword, upper bits zero
//   width_out      out  codeword_width of the word on codeword_out
// ---------------------------------------------------------------------------
module enc_codeword_gen #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CW_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        codeword_width,
`ifdef ENC_ERR_INJECT_EN
  input  logic              err_inj,
  input  logic [4:0]        err_inj_pos,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   codeword_out,
  output logic [1:0]        width_out
);

  typedef enum logic [1:0] {
    CW8  = 2'b00,
    CW16 = 2'b01,
    CW32 = 2'b10
  } cw_mode_e;

  // Stage 1: sampled inputs
  logic        s1_valid_q;
  logic [25:0] s1_data_q;
  logic [1:0]  s1_width_q;
`ifdef ENC_ERR_INJECT_EN
  logic        s1_err_q;
  logic [4:0]  s1_pos_q;
`endif

  // Stage 2: finished codeword
  logic        s2_valid_q;
  logic [31:0] s2_cw_q;
  logic [1:0]  s2_width_q;
  logic [31:0] s2_cw_d;

  logic        s1_adv;
  logic        s2_adv;
  cw_mode_e    s1_mode;

  // Ready chain is purely combinational from out_ready and stage valids.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Hamming encoder for an N-bit codeword. N is always a constant at the
  // call site, so every loop unrolls into a fixed XOR network.
  function automatic logic [31:0] encode(input logic [25:0] d,
                                         input int unsigned n);
    logic [31:0] cw;
    logic [4:0]  idx;
    logic        par;
    cw  = '0;
    idx = '0;
    // Data bits go to the non-power-of-two positions, lowest first.
    for (int unsigned p = 3; p < 32; p++) begin
      if (p < n && (p & (p - 1)) != 0) begin
        cw[p] = d[idx];
        idx   = idx + 5'd1;
      end
    end
    // Parity positions are still zero here, so including them is harmless.
    for (int unsigned k = 0; k < 5; k++) begin
      if ((32'd1 << k) < n) begin
        par = 1'b0;
        for (int unsigned p = 1; p < 32; p++) begin
          if (p < n && ((p >> k) & 32'd1) == 32'd1) begin
            par = par ^ cw[p];
          end
        end
        cw[32'd1 << k] = par;
      end
    end
    cw[0] = ^cw[31:1];
    return cw;
  endfunction

  always_comb begin
    case (s1_width_q)
      2'b00:   s1_mode = CW8;
      2'b01:   s1_mode = CW16;
      default: s1_mode = CW32;
    endcase
  end

  always_comb begin
    s2_cw_d = '0;
    case (s1_mode)
      CW8:     s2_cw_d = encode(s1_data_q, 8);
      CW16:    s2_cw_d = encode(s1_data_q, 16);
      default: s2_cw_d = encode(s1_data_q, 32);
    endcase
`ifdef ENC_ERR_INJECT_EN
    if (s1_err_q) begin
      case (s1_mode)
        CW8:     if (s1_pos_q < 5'd8)  s2_cw_d[s1_pos_q] = ~s2_cw_d[s1_pos_q];
        CW16:    if (s1_pos_q < 5'd16) s2_cw_d[s1_pos_q] = ~s2_cw_d[s1_pos_q];
        default: s2_cw_d[s1_pos_q] = ~s2_cw_d[s1_pos_q];
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_width_q <= '0;
`ifdef ENC_ERR_INJECT_EN
      s1_err_q   <= 1'b0;
      s1_pos_q   <= '0;
`endif
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q  <= data_in[25:0];
        s1_width_q <= codeword_width;
`ifdef ENC_ERR_INJECT_EN
        s1_err_q   <= err_inj;
        s1_pos_q   <= err_inj_pos;
`endif
      end
    end
  end

  // S2 data only loads with a real word, so the output holds while stalled
  // and after draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_cw_q    <= '0;
      s2_width_q <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_cw_q    <= s2_cw_d;
        s2_width_q <= s1_width_q;
      end
    end
  end

  always_comb begin
    codeword_out       = '0;
    codeword_out[31:0] = s2_cw_q;
  end

  assign out_valid = s2_valid_q;
  assign width_out = s2_width_q;

endmodule

// File: tb/tb_enc_codeword_gen.sv
module tb_enc_codeword_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_in = '0;
  logic [1:0]  codeword_width = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] codeword_out;
  logic [1:0]  width_out;
`ifdef ENC_ERR_INJECT_EN
  logic        err_inj = 1'b0;
  logic [4:0]  err_inj_pos = '0;
`endif

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int          ready_mode = 0;   // 0: held by test, 1: toggle, 2: random
  logic [33:0] expq[$];

  enc_codeword_gen #(.DATA_W(32), .CW_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_in        (data_in),
    .codeword_width (codeword_width),
`ifdef ENC_ERR_INJECT_EN
    .err_inj        (err_inj),
    .err_inj_pos    (err_inj_pos),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .codeword_out   (codeword_out),
    .width_out      (width_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: data bits placed at non-power-of-two positions; the check
  // bits equal the XOR of the indices of all set data positions; bit 0
  // makes the total number of ones even.
  function automatic logic [31:0] model_cw(input logic [31:0] data, input logic [1:0] w,
                                           input logic inj, input logic [4:0] pos);
    int n;
    int j;
    int syn;
    logic [31:0] cw;
    n   = (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
    cw  = '0;
    syn = 0;
    j   = 0;
    for (int p = 1; p < n; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (data[j]) begin
          cw[p] = 1'b1;
          syn   = syn ^ p;
        end
        j++;
      end
    end
    for (int k = 0; k < 5; k++)
      if ((1 << k) < n) cw[1 << k] = syn[k];
    cw[0] = ($countones(cw) % 2) != 0;
    if (inj && int'(pos) < n) cw[pos] = ~cw[pos];
    return cw;
  endfunction

  // out_ready driver
  initial forever begin
    @(posedge clk); #1;
    if (ready_mode == 1) out_ready = ~out_ready;
    else if (ready_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard / compare process
  logic        stalled = 1'b0;
  logic [31:0] stall_cw;
  logic [1:0]  stall_w;
  always @(negedge clk) begin
    logic [33:0] e;
    logic        inj;
    logic [4:0]  pos;
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_cw", codeword_out, stall_cw);
        check("stall_width", {30'b0, width_out}, {30'b0, stall_w});
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_out", {31'b0, out_valid}, 32'd0);
        end else begin
          e = expq[0];
          check("codeword", codeword_out, e[31:0]);
          check("width_out", {30'b0, width_out}, {30'b0, e[33:32]});
          if (out_ready) void'(expq.pop_front());
        end
      end
      stalled  = out_valid && !out_ready;
      stall_cw = codeword_out;
      stall_w  = width_out;
      inj = 1'b0;
      pos = '0;
`ifdef ENC_ERR_INJECT_EN
      inj = err_inj;
      pos = err_inj_pos;
`endif
      if (in_valid && in_ready)
        expq.push_back({codeword_width, model_cw(data_in, codeword_width, inj, pos)});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [1:0] w);
    int   t;
    logic acc;
    t = 0;
    in_valid = 1'b1;
    data_in = d;
    codeword_width = w;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) check("send_timeout", {31'b0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    ready_mode = 0;
    out_ready = 1'b1;
    while ((expq.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", expq.size(), 32'd0);
  endtask

  initial begin
    // Model pinned against hand-computed codewords
    check("model_8b", model_cw(32'hB, 2'b00, 1'b0, 5'd0), 32'h000000AA);
    check("model_16b", model_cw(32'h7FF, 2'b01, 1'b0, 5'd0), 32'h0000FFFF);
    check("model_32b", model_cw(32'h3FFFFFF, 2'b10, 1'b0, 5'd0), 32'hFFFFFFFF);
    check("model_upper_ign", model_cw(32'hFFFFFFF0, 2'b00, 1'b0, 5'd0), 32'h0);
    check("model_inj3", model_cw(32'hB, 2'b00, 1'b1, 5'd3), 32'h000000A2);

    // Reset state
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_codeword", codeword_out, 32'd0);
    check("rst_width", {30'b0, width_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

    // Latency: 2 edges from accept to out_valid, literal codeword
    in_valid = 1'b1; data_in = 32'hB; codeword_width = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_1cycle_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_2cycle_valid", {31'b0, out_valid}, 32'd1);
    check("lat_cw_literal", codeword_out, 32'h000000AA);
    check("lat_width_literal", {30'b0, width_out}, 32'd0);
    drain();

    // Directed patterns, mixed widths back to back
    send(32'h7FF, 2'b01);
    send(32'h3FFFFFF, 2'b10);
    send(32'h0, 2'b00);
    send(32'h0, 2'b01);
    send(32'h0, 2'b10);
    send(32'hFFFFFFF0, 2'b00);
    send(32'hFFFFFFFF, 2'b11);
    drain();

    // 8 words with out_ready toggling every cycle
    ready_mode = 1;
    for (int i = 0; i < 8; i++) send($urandom, 2'($urandom_range(0, 3)));
    drain();

`ifdef ENC_ERR_INJECT_EN
    err_inj = 1'b1; err_inj_pos = 5'd3;
    send(32'hB, 2'b00);
    err_inj_pos = 5'd9;
    send(32'hB, 2'b00);
    err_inj = 1'b0;
    drain();
`endif

    // Random traffic; inputs change freely even when not accepted
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      data_in = $urandom;
      codeword_width = 2'($urandom_range(0, 3));
`ifdef ENC_ERR_INJECT_EN
      err_inj = ($urandom_range(0, 3) == 0);
      err_inj_pos = 5'($urandom_range(0, 31));
`endif
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
`ifdef ENC_ERR_INJECT_EN
    err_inj = 1'b0;
`endif
    drain();

    // Reset with two words in flight
    ready_mode = 0;
    out_ready = 1'b0;
    send(32'h5, 2'b00);
    send(32'h6, 2'b01);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_codeword", codeword_out, 32'd0);
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {31'b0, out_valid}, 32'd0);
    end

    // Traffic resumes normally after reset
    send(32'hB, 2'b00);
    send(32'h7FF, 2'b01);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
